// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared types for the writeback trace recorder.
//   wb_entry_t     - one captured writeback event {pc, wen, wnum, wdata, lane}
//   trig_state_t   - trigger/post FSM encoding (IDLE, POST, FROZEN)
//   MODE_STREAM / MODE_WINDOW - values of the recorder's mode input
//   ev_valid()     - a lane carries an event when it writes a non-zero register
package wb_trace_pkg;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_WINDOW = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        lane;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trig_state_t;

  // Writes to r0 are architecturally discarded, so they are not trace events.
  function automatic logic ev_valid(input logic [3:0] wen, input logic [4:0] wnum);
    return (wen != 4'd0) && (wnum != 5'd0);
  endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// wb_trace_mem: DEPTH-entry flop array holding trace entries.
//   clk, rst_n          - clock, async active-low reset (clears all entries)
//   i_we0/i_addr0/i_data0 - write port 0 (older lane)
//   i_we1/i_addr1/i_data1 - write port 1 (younger lane)
//   i_raddr / o_rdata   - combinational read port (buffer head)
// The parent never presents equal addresses on both ports in one cycle.
module wb_trace_mem
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we0,
  input  logic [AW-1:0] i_addr0,
  input  wb_entry_t     i_data0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  wb_entry_t     i_data1,
  input  logic [AW-1:0] i_raddr,
  output wb_entry_t     o_rdata
);

  wb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_we0) r_mem[i_addr0] <= i_data0;
      if (i_we1) r_mem[i_addr1] <= i_data1;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_recorder.sv
// wb_trace_recorder: captures CPU writeback events from LANES commit lanes
// into a circular buffer and drains them through a valid/ready port.
//   clk, resetn                    - clock, async active-low reset
//   in_pc/in_wen/in_wnum/in_wdata  - per-lane writeback observation inputs
//   mode, clear                    - STREAM/WINDOW select, synchronous flush
//   trig_en/trig_pc/trig_post      - WINDOW trigger PC and post-trigger length
//   out_valid/out_ready/out_*      - head entry drain port
//   count, drop_cnt                - occupancy, saturating STREAM loss counter
//   trig_hit, frozen               - WINDOW trigger recorded / capture complete
//   dbg_state                      - trigger FSM state
// Handshake: out_valid/out_* describe the head entry; the head is consumed at a
// rising edge where out_valid && out_ready, and until then out_valid stays high
// and out_* stay stable. out_valid never depends on out_ready.
module wb_trace_recorder
  import wb_trace_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [32*LANES-1:0]        in_pc,
  input  logic [4*LANES-1:0]         in_wen,
  input  logic [5*LANES-1:0]         in_wnum,
  input  logic [32*LANES-1:0]        in_wdata,
  input  logic                       mode,
  input  logic                       clear,
  input  logic                       trig_en,
  input  logic [31:0]                trig_pc,
  input  logic [$clog2(DEPTH)-1:0]   trig_post,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [3:0]                 out_wen,
  output logic [4:0]                 out_wnum,
  output logic [31:0]                out_wdata,
  output logic                       out_lane,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       trig_hit,
  output logic                       frozen,
  output logic [1:0]                 dbg_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;
  localparam int DW1 = DROP_W + 1;

  logic [AW-1:0]     r_head, r_tail, r_post;
  logic [CW-1:0]     r_count;
  logic [DROP_W-1:0] r_drop;
  trig_state_t       r_state;

  wb_entry_t         w_ent0, w_ent1, w_head_ent;
  logic              w_ev0, w_ev1, w_we0, w_we1, w_pop;
  logic [1:0]        w_drop_inc;
  logic [CW1-1:0]    w_free, w_nwr, w_sum;
  logic [DW1-1:0]    w_drop_sum;
  logic [AW-1:0]     w_addr1, w_nhead, w_ntail, w_npost;
  logic [CW-1:0]     w_ncount;
  logic [DROP_W-1:0] w_ndrop;
  trig_state_t       w_nstate;

  assign w_ent0 = '{pc: in_pc[31:0], wen: in_wen[3:0], wnum: in_wnum[4:0],
                    wdata: in_wdata[31:0], lane: 1'b0};

  generate
    if (LANES > 1) begin : g_dual
      assign w_ent1 = '{pc: in_pc[63:32], wen: in_wen[7:4], wnum: in_wnum[9:5],
                        wdata: in_wdata[63:32], lane: 1'b1};
    end else begin : g_single
      assign w_ent1 = '0;
    end
  endgenerate

  assign w_ev0 = ev_valid(w_ent0.wen, w_ent0.wnum);
  assign w_ev1 = ev_valid(w_ent1.wen, w_ent1.wnum);

  // WINDOW entries are only readable once the capture is frozen.
  assign out_valid = (r_count != '0) && ((mode == MODE_STREAM) || (r_state == ST_FROZEN));
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_we0      = 1'b0;
    w_we1      = 1'b0;
    w_drop_inc = 2'd0;
    w_nstate   = r_state;
    w_npost    = r_post;
    // The slot freed by a same-cycle pop is usable by this cycle's pushes.
    w_free     = CW1'(DEPTH) - CW1'(r_count) + CW1'(w_pop);

    if (mode == MODE_STREAM) begin
      w_we0      = w_ev0 && (w_free != '0);
      w_we1      = w_ev1 && (w_free > CW1'(w_we0));
      w_drop_inc = 2'(w_ev0 && !w_we0) + 2'(w_ev1 && !w_we1);
    end else begin
      // Lane 0 is evaluated first; lane 1 sees the FSM as lane 0 left it, so
      // a lane 0 trigger with trig_post == 0 already blocks lane 1.
      if (w_ev0 && ((w_nstate == ST_IDLE) || ((w_nstate == ST_POST) && (w_npost != '0)))) begin
        w_we0 = 1'b1;
        if (w_nstate == ST_IDLE) begin
          if (trig_en && (w_ent0.pc == trig_pc)) begin
            w_nstate = ST_POST;
            w_npost  = trig_post;
          end
        end else begin
          w_npost = w_npost - AW'(1);
        end
      end
      if (w_ev1 && ((w_nstate == ST_IDLE) || ((w_nstate == ST_POST) && (w_npost != '0)))) begin
        w_we1 = 1'b1;
        if (w_nstate == ST_IDLE) begin
          if (trig_en && (w_ent1.pc == trig_pc)) begin
            w_nstate = ST_POST;
            w_npost  = trig_post;
          end
        end else begin
          w_npost = w_npost - AW'(1);
        end
      end
      // Post counter reached zero at the previous edge: nothing was stored
      // this cycle, and the capture freezes now.
      if ((r_state == ST_POST) && (r_post == '0)) w_nstate = ST_FROZEN;
    end

    w_addr1 = r_tail + AW'(w_we0);
    w_nwr   = CW1'(w_we0) + CW1'(w_we1);
    w_ntail = r_tail + AW'(w_nwr);
    w_sum   = CW1'(r_count) + w_nwr - CW1'(w_pop);
    // Only WINDOW can overshoot; the excess entries are the oldest ones.
    if (w_sum > CW1'(DEPTH)) begin
      w_ncount = CW'(DEPTH);
      w_nhead  = r_head + AW'(w_sum - CW1'(DEPTH));
    end else begin
      w_ncount = CW'(w_sum);
      w_nhead  = r_head + AW'(w_pop);
    end

    w_drop_sum = {1'b0, r_drop} + DW1'(w_drop_inc);
    w_ndrop    = w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_post  <= '0;
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_post  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_head  <= w_nhead;
      r_tail  <= w_ntail;
      r_count <= w_ncount;
      r_drop  <= w_ndrop;
      r_post  <= w_npost;
      r_state <= w_nstate;
    end
  end

  wb_trace_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst_n   (resetn),
    .i_we0   (w_we0 && !clear),
    .i_addr0 (r_tail),
    .i_data0 (w_ent0),
    .i_we1   (w_we1 && !clear),
    .i_addr1 (w_addr1),
    .i_data1 (w_ent1),
    .i_raddr (r_head),
    .o_rdata (w_head_ent)
  );

  assign out_pc    = w_head_ent.pc;
  assign out_wen   = w_head_ent.wen;
  assign out_wnum  = w_head_ent.wnum;
  assign out_wdata = w_head_ent.wdata;
  assign out_lane  = w_head_ent.lane;
  assign count     = r_count;
  assign drop_cnt  = r_drop;
  assign trig_hit  = (r_state != ST_IDLE);
  assign frozen    = (r_state == ST_FROZEN);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wb_trace_recorder.sv
module tb_wb_trace_recorder;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;
  localparam int W     = 74;

  logic              clk = 1'b0;
  logic              resetn;
  logic [63:0]       in_pc, in_wdata;
  logic [7:0]        in_wen;
  logic [9:0]        in_wnum;
  logic              mode, clear, trig_en, out_ready;
  logic [31:0]       trig_pc;
  logic [AW-1:0]     trig_post;
  logic              out_valid, out_lane, trig_hit, frozen;
  logic [31:0]       out_pc, out_wdata;
  logic [3:0]        out_wen;
  logic [4:0]        out_wnum;
  logic [CW-1:0]     count;
  logic [15:0]       drop_cnt;
  logic [1:0]        dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  wb_trace_recorder #(.LANES(LANES), .DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_pc(in_pc), .in_wen(in_wen), .in_wnum(in_wnum),
    .in_wdata(in_wdata), .mode(mode), .clear(clear), .trig_en(trig_en),
    .trig_pc(trig_pc), .trig_post(trig_post), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum),
    .out_wdata(out_wdata), .out_lane(out_lane), .count(count), .drop_cnt(drop_cnt),
    .trig_hit(trig_hit), .frozen(frozen), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- event vectors ----------------
  function automatic logic [31:0] ev_pc(input int k);
    return 32'h0000_1000 + 32'(k * 4);
  endfunction
  function automatic logic [3:0] ev_wen(input int k);
    return 4'(k) | 4'h1;
  endfunction
  function automatic logic [4:0] ev_wnum(input int k);
    return 5'((k % 31) + 1);
  endfunction
  function automatic logic [31:0] ev_wdata(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction
  function automatic logic [W-1:0] ev_ent(input int k, input bit lane);
    return {ev_pc(k), ev_wen(k), ev_wnum(k), ev_wdata(k), lane};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    in_pc = '0; in_wen = '0; in_wnum = '0; in_wdata = '0;
  endtask

  task automatic set_lane(input int lane, input int k);
    in_pc[32*lane +: 32]   = ev_pc(k);
    in_wen[4*lane +: 4]    = ev_wen(k);
    in_wnum[5*lane +: 5]   = ev_wnum(k);
    in_wdata[32*lane +: 32] = ev_wdata(k);
  endtask

  task automatic clear_to(input logic m);
    out_ready = 1'b0;
    idle_lanes();
    mode  = m;
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drain_n(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL mon_unexpected: got %h expected no entry",
                 {out_pc, out_wen, out_wnum, out_wdata, out_lane});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_wen, out_wnum, out_wdata, out_lane} !== e) begin
          n_errors++;
          $display("FAIL mon_entry: got %h expected %h",
                   {out_pc, out_wen, out_wnum, out_wdata, out_lane}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; mode = 1'b0; clear = 1'b0; trig_en = 1'b0;
    trig_pc = '0; trig_post = '0; out_ready = 1'b0;
    idle_lanes();
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_trig_hit", 64'(trig_hit), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_out_fields", 64'({out_pc, out_wnum, out_wen, out_lane}), 64'd0);
    chk("rst_out_wdata", 64'(out_wdata), 64'd0);
    resetn = 1'b1;
    step();

    // STREAM, single lane: 10 events into 8 slots, readout 1..8
    clear_to(1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle_lanes();
      set_lane(0, k);
      if (k <= DEPTH) exp_q.push_back(ev_ent(k, 1'b0));
      step();
    end
    idle_lanes();
    chk("s1_count", 64'(count), 64'd8);
    chk("s1_drop", 64'(drop_cnt), 64'd2);
    drain(20);
    chk("s1_count_empty", 64'(count), 64'd0);

    // STREAM, dual lane: leave one slot, then fire both lanes
    clear_to(1'b0);
    for (int p = 0; p < 3; p++) begin
      idle_lanes();
      set_lane(0, 2*p + 1);
      set_lane(1, 2*p + 2);
      exp_q.push_back(ev_ent(2*p + 1, 1'b0));
      exp_q.push_back(ev_ent(2*p + 2, 1'b1));
      step();
    end
    idle_lanes();
    set_lane(0, 7);
    exp_q.push_back(ev_ent(7, 1'b0));
    step();
    chk("s2_count7", 64'(count), 64'd7);
    set_lane(0, 8);
    set_lane(1, 9);
    exp_q.push_back(ev_ent(8, 1'b0));
    step();
    idle_lanes();
    chk("s2_count_full", 64'(count), 64'd8);
    chk("s2_drop", 64'(drop_cnt), 64'd1);

    // STREAM, full buffer with continuous pop
    out_ready = 1'b1;
    set_lane(0, 10);
    exp_q.push_back(ev_ent(10, 1'b0));
    step();
    chk("s3_pop_reuse_count", 64'(count), 64'd8);
    chk("s3_pop_reuse_drop", 64'(drop_cnt), 64'd1);
    for (int j = 0; j < 3; j++) begin
      idle_lanes();
      set_lane(0, 11 + 2*j);
      set_lane(1, 12 + 2*j);
      exp_q.push_back(ev_ent(11 + 2*j, 1'b0));
      step();
    end
    idle_lanes();
    chk("s3_dual_full_drop", 64'(drop_cnt), 64'd4);
    chk("s3_dual_full_count", 64'(count), 64'd8);
    drain(20);
    chk("s3_empty", 64'(count), 64'd0);
    out_ready = 1'b1;
    set_lane(0, 20); set_lane(1, 21);
    exp_q.push_back(ev_ent(20, 1'b0)); exp_q.push_back(ev_ent(21, 1'b1));
    step();
    set_lane(0, 22); set_lane(1, 23);
    exp_q.push_back(ev_ent(22, 1'b0)); exp_q.push_back(ev_ent(23, 1'b1));
    step();
    idle_lanes();
    chk("s3_order_count", 64'(count), 64'd3);
    drain(10);
    chk("s3_nodrop", 64'(drop_cnt), 64'd4);

    // WINDOW, trig_post=3, trigger on event 12
    trig_en = 1'b1; trig_pc = ev_pc(12); trig_post = 3'd3;
    clear_to(1'b1);
    for (int k = 1; k <= 18; k++) begin
      idle_lanes();
      set_lane(k % 2, k);
      step();
      if (k == 11) chk("w1_no_hit_yet", 64'(trig_hit), 64'd0);
      if (k == 12) begin
        chk("w1_hit", 64'(trig_hit), 64'd1);
        chk("w1_not_frozen_at_trig", 64'(frozen), 64'd0);
      end
      if (k == 15) begin
        chk("w1_not_frozen_ev15", 64'(frozen), 64'd0);
        chk("w1_valid_hidden", 64'(out_valid), 64'd0);
        chk("w1_count", 64'(count), 64'd8);
      end
      if (k == 16) chk("w1_frozen", 64'(frozen), 64'd1);
    end
    idle_lanes();
    chk("w1_count_frozen", 64'(count), 64'd8);
    chk("w1_drop", 64'(drop_cnt), 64'd0);
    for (int k = 8; k <= 15; k++) exp_q.push_back(ev_ent(k, 1'(k % 2)));
    drain(20);
    chk("w1_frozen_after_drain", 64'(frozen), 64'd1);
    chk("w1_valid_after_drain", 64'(out_valid), 64'd0);

    // WINDOW, trig_post=0, lane 0 triggers in a dual-lane cycle
    trig_pc = ev_pc(33); trig_post = 3'd0;
    clear_to(1'b1);
    chk("w2_clear_frozen", 64'(frozen), 64'd0);
    for (int k = 30; k <= 32; k++) begin
      idle_lanes();
      set_lane(0, k);
      exp_q.push_back(ev_ent(k, 1'b0));
      step();
    end
    set_lane(0, 33); set_lane(1, 34);
    exp_q.push_back(ev_ent(33, 1'b0));
    step();
    chk("w2_hit", 64'(trig_hit), 64'd1);
    chk("w2_lane1_blocked", 64'(count), 64'd4);
    chk("w2_not_frozen_yet", 64'(frozen), 64'd0);
    set_lane(0, 35); set_lane(1, 36);
    step();
    chk("w2_frozen", 64'(frozen), 64'd1);
    chk("w2_dbg_state", 64'(dbg_state), 64'd2);
    set_lane(0, 37); set_lane(1, 38);
    step();
    idle_lanes();
    chk("w2_ignored", 64'(count), 64'd4);
    chk("w2_valid", 64'(out_valid), 64'd1);
    drain_n(2);
    chk("w2_partial", 64'(count), 64'd2);

    // clear mid-drain
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_frozen", 64'(frozen), 64'd0);
    chk("clr_trig_hit", 64'(trig_hit), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // reset mid-drain, with drops pending
    trig_en = 1'b0;
    clear_to(1'b0);
    for (int k = 40; k <= 49; k++) begin
      idle_lanes();
      set_lane(0, k);
      if (k < 48) exp_q.push_back(ev_ent(k, 1'b0));
      step();
    end
    idle_lanes();
    chk("r_drop_before", 64'(drop_cnt), 64'd2);
    drain_n(3);
    chk("r_count_before", 64'(count), 64'd5);
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("r_valid", 64'(out_valid), 64'd0);
    chk("r_count", 64'(count), 64'd0);
    chk("r_drop", 64'(drop_cnt), 64'd0);
    chk("r_frozen", 64'(frozen), 64'd0);
    chk("r_out_pc", 64'(out_pc), 64'd0);
    step();
    resetn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
